cache_sync_ctrl: RTL and testbench
==================================

Name: cache_sync_ctrl

Overview:
- Sequences the cache-maintenance operations raised by the decoder's sync-icache and sync-dcache instructions.
- Stalls the pipeline while it walks the data cache line by line, writing back dirty lines and optionally invalidating them.
- For an icache sync it then invalidates every instruction-cache line.
- Sits beside the decode stage; drives the dcache/icache maintenance ports and the global stall.

Parameters:
- DCACHE_LINES, 64: number of dcache lines walked; power of two, >=2.
- ICACHE_LINES, 64: number of icache lines invalidated; power of two, >=2.
- IDX_W, 6: index width; must equal clog2(max(DCACHE_LINES, ICACHE_LINES)).

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode stage holds a valid instruction
- sync_icache_i  in  1  decoded instruction is sync-icache
- sync_dcache_i  in  1  decoded instruction is sync-dcache
- stall_o  out  1  hold fetch/decode
- busy_o  out  1  walk in progress (state not IDLE/DONE)
- done_o  out  1  one-cycle completion pulse
- dc_idx_o  out  IDX_W  dcache line index
- dc_probe_o  out  1  read tag/status of dc_idx_o
- dc_valid_i  in  1  probed line valid; sampled the cycle after dc_probe_o
- dc_dirty_i  in  1  probed line dirty; same timing
- dc_wb_req_o  out  1  write back line dc_idx_o
- dc_wb_ack_i  in  1  write-back complete
- dc_inv_o  out  1  invalidate line dc_idx_o, one cycle
- ic_idx_o  out  IDX_W  icache line index
- ic_inv_o  out  1  invalidate line ic_idx_o, one cycle

Behaviour:
- Reset: state IDLE, index 0, mode flags 0; every output 0. Async reset mid-walk abandons the walk immediately; an in-flight write-back is the cache's concern. The next sync restarts at index 0.
- Start: in IDLE, when id_valid_i && (sync_icache_i || sync_dcache_i):
  - latch do_dinv = sync_dcache_i and do_iinv = sync_icache_i;
  - index = 0; go to DC_PROBE.
  - Both flags set = union: dcache write-back+invalidate, then icache invalidate.
- stall_o = (IDLE && id_valid_i && (sync_icache_i || sync_dcache_i)) || busy_o. stall_o is combinational, so the sync instruction is held from its decode cycle.
- FSM:
  - IDLE: see Start.
  - DC_PROBE: dc_probe_o=1, dc_idx_o=index; go to DC_CHECK.
  - DC_CHECK: sample dc_valid_i/dc_dirty_i.
    - valid&&dirty -> DC_WB.
    - valid&&!dirty&&do_dinv -> DC_INV.
    - otherwise -> DC_NEXT.
  - DC_WB: dc_wb_req_o=1, held until the cycle dc_wb_ack_i=1; ack may arrive on the first DC_WB cycle. Exit to DC_INV if do_dinv, else DC_NEXT. dc_wb_ack_i outside DC_WB is ignored.
  - DC_INV: dc_inv_o=1 for exactly one cycle -> DC_NEXT.
  - DC_NEXT (no cycle spent; transition logic only):
    - index==DCACHE_LINES-1: index=0, then IC_INV if do_iinv, else DONE.
    - otherwise: index+1 -> DC_PROBE.
  - IC_INV: ic_inv_o=1, ic_idx_o=index, one line per cycle. After ICACHE_LINES-1, go to DONE.
  - DONE: stall_o=0, done_o=1 for one cycle; sync inputs ignored; -> IDLE. The held instruction advances on this edge.
- Index/timing rules:
  - dc_idx_o is constant from DC_PROBE through that line's DC_INV.
  - dc_idx_o and ic_idx_o show the index only while their strobes are active; otherwise 0.
  - Clean walk latency: 1 decode cycle + 2·DCACHE_LINES, plus ICACHE_LINES if do_iinv, then DONE.
- Index counter: IDX_W bits. Wrap only at the explicit terminal compare, never by overflow.

Decomposition:
- Shared header cache_sync_defs: state encodings (IDLE, DC_PROBE, DC_CHECK, DC_WB, DC_INV, IC_INV, DONE) and the IDX_W helper.
- Single module, no sub-module; index counter and FSM inline.

Test Plan:
(All with DCACHE_LINES=4, ICACHE_LINES=4.)
1. sync_dcache, all lines invalid -> stall_o high 9 cycles; done_o at cycle 9; no dc_wb_req_o, dc_inv_o or ic_inv_o.
2. sync_dcache, line 2 valid+dirty, ack 3 cycles after req -> dc_wb_req_o high exactly 3 cycles with dc_idx_o=2; then dc_inv_o one cycle idx 2; done after 4 lines.
3. sync_icache, line 1 valid+dirty, ack same cycle -> one-cycle dc_wb_req_o idx 1; no dc_inv_o; ic_inv_o on 4 consecutive cycles, idx 0,1,2,3; then done_o.
4. sync_icache and sync_dcache together, all lines valid clean -> dc_inv_o for idx 0..3; then ic_inv_o for idx 0..3.
5. rst_n low during DC_WB at line 1 -> all outputs 0 immediately; a new sync_dcache probes idx 0 first.
6. sync_dcache with id_valid_i=0 -> stall_o stays 0, state stays IDLE; spurious dc_wb_ack_i in IDLE has no effect.

Source files
------------

// File: rtl/cache_sync_ctrl_pkg.sv
// Shared definitions for the cache maintenance sequencer:
// FSM state encodings and the index-width helper.
package cache_sync_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] S_DC_PROBE = 3'd1;
  localparam logic [STATE_W-1:0] S_DC_CHECK = 3'd2;
  localparam logic [STATE_W-1:0] S_DC_WB    = 3'd3;
  localparam logic [STATE_W-1:0] S_DC_INV   = 3'd4;
  localparam logic [STATE_W-1:0] S_IC_INV   = 3'd5;
  localparam logic [STATE_W-1:0] S_DONE     = 3'd6;

  // Index width needed to address the larger of the two caches.
  function automatic int idx_w_f(input int d_lines,
                                 input int i_lines);
    int m;
    m = (d_lines > i_lines) ? d_lines : i_lines;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/cache_sync_ctrl.sv
// Sequencer for sync-icache / sync-dcache: walks the dcache
// writing back dirty lines, then optionally sweeps the icache.
module cache_sync_ctrl
  import cache_sync_ctrl_pkg::*;
#(
  parameter int DCACHE_LINES = 64,
  parameter int ICACHE_LINES = 64,
  parameter int IDX_W        = 6
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic             sync_icache_i,
  input  logic             sync_dcache_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] dc_idx_o,
  output logic             dc_probe_o,
  input  logic             dc_valid_i,
  input  logic             dc_dirty_i,
  output logic             dc_wb_req_o,
  input  logic             dc_wb_ack_i,
  output logic             dc_inv_o,
  output logic [IDX_W-1:0] ic_idx_o,
  output logic             ic_inv_o
);

  localparam logic [IDX_W-1:0] DC_LAST =
    IDX_W'(DCACHE_LINES - 1);
  localparam logic [IDX_W-1:0] IC_LAST =
    IDX_W'(ICACHE_LINES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               do_dinv_q, do_dinv_d;
  logic               do_iinv_q, do_iinv_d;
  logic               start;
  logic               adv;

  assign start = id_valid_i
               & (sync_icache_i | sync_dcache_i);

  // Next-state, index and mode-flag logic; adv folds the
  // zero-cycle DC_NEXT step into whichever state finishes a line.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    do_dinv_d = do_dinv_q;
    do_iinv_d = do_iinv_q;
    adv       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          do_dinv_d = sync_dcache_i;
          do_iinv_d = sync_icache_i;
          idx_d     = '0;
          state_d   = S_DC_PROBE;
        end
      end
      S_DC_PROBE: state_d = S_DC_CHECK;
      S_DC_CHECK: begin
        if (dc_valid_i && dc_dirty_i) begin
          state_d = S_DC_WB;
        end else if (dc_valid_i && do_dinv_q) begin
          state_d = S_DC_INV;
        end else begin
          adv = 1'b1;
        end
      end
      S_DC_WB: begin
        if (dc_wb_ack_i) begin
          if (do_dinv_q) state_d = S_DC_INV;
          else           adv     = 1'b1;
        end
      end
      S_DC_INV: adv = 1'b1;
      S_IC_INV: begin
        if (idx_q == IC_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        do_dinv_d = 1'b0;
        do_iinv_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        idx_d     = '0;
        do_dinv_d = 1'b0;
        do_iinv_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    if (adv) begin
      if (idx_q == DC_LAST) begin
        idx_d   = '0;
        state_d = do_iinv_q ? S_IC_INV : S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_DC_PROBE;
      end
    end
  end

  // State, index and mode flags; reset abandons any walk.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      do_dinv_q <= 1'b0;
      do_iinv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      do_dinv_q <= do_dinv_d;
      do_iinv_q <= do_iinv_d;
    end
  end

  // Moore strobes; indices are forced to zero unless a strobe
  // is qualifying them, and stall covers the decode cycle.
  always_comb begin
    dc_probe_o  = (state_q == S_DC_PROBE);
    dc_wb_req_o = (state_q == S_DC_WB);
    dc_inv_o    = (state_q == S_DC_INV);
    ic_inv_o    = (state_q == S_IC_INV);
    done_o      = (state_q == S_DONE);
    busy_o      = (state_q != S_IDLE)
                & (state_q != S_DONE);
    stall_o     = ((state_q == S_IDLE) & start) | busy_o;
    dc_idx_o    = '0;
    ic_idx_o    = '0;
    if (dc_probe_o || dc_wb_req_o || dc_inv_o) dc_idx_o = idx_q;
    if (ic_inv_o) ic_idx_o = idx_q;
  end

endmodule

// File: tb/tb_cache_sync_ctrl.sv
// Scoreboard bench for cache_sync_ctrl with 4-line caches:
// a cache responder, an event monitor and directed syncs.
module tb_cache_sync_ctrl;

  localparam int DL = 4;
  localparam int IL = 4;
  localparam int IW = 2;

  localparam int K_PROBE = 1;
  localparam int K_WB    = 2;
  localparam int K_DINV  = 3;
  localparam int K_IINV  = 4;
  localparam int K_DONE  = 5;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid_i = 1'b0;
  logic          sync_icache_i = 1'b0;
  logic          sync_dcache_i = 1'b0;
  logic          stall_o, busy_o, done_o;
  logic [IW-1:0] dc_idx_o, ic_idx_o;
  logic          dc_probe_o, dc_wb_req_o, dc_inv_o, ic_inv_o;
  logic          dc_valid_i = 1'b0;
  logic          dc_dirty_i = 1'b0;
  logic          dc_wb_ack_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];
  bit mon_en = 1'b0;

  bit lv[DL];
  bit ld[DL];
  int ack_lat = 1;
  bit spur_ack = 1'b0;
  int wbcnt = 0;
  bit probed = 1'b0;
  int pidx = 0;

  cache_sync_ctrl #(
    .DCACHE_LINES(DL),
    .ICACHE_LINES(IL),
    .IDX_W(IW)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .id_valid_i(id_valid_i),
    .sync_icache_i(sync_icache_i),
    .sync_dcache_i(sync_dcache_i),
    .stall_o(stall_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .dc_idx_o(dc_idx_o),
    .dc_probe_o(dc_probe_o),
    .dc_valid_i(dc_valid_i),
    .dc_dirty_i(dc_dirty_i),
    .dc_wb_req_o(dc_wb_req_o),
    .dc_wb_ack_i(dc_wb_ack_i),
    .dc_inv_o(dc_inv_o),
    .ic_idx_o(ic_idx_o),
    .ic_inv_o(ic_inv_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input int act,
                       input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input int k, input int idx);
    int e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d idx %0d, expected none",
               k, idx);
    end else begin
      e = sb.pop_front();
      if (e != k * 256 + idx) begin
        n_bad++;
        $display("FAIL event: got kind %0d idx %0d expected kind %0d idx %0d",
                 k, idx, e / 256, e % 256);
      end
    end
  endtask

  // Monitor: every strobe seen must match the head of the queue.
  always @(negedge sys_clk) begin
    if (mon_en && rst_n) begin
      if (dc_probe_o)  chk_ev(K_PROBE, int'(dc_idx_o));
      if (dc_wb_req_o) chk_ev(K_WB, int'(dc_idx_o));
      if (dc_inv_o)    chk_ev(K_DINV, int'(dc_idx_o));
      if (ic_inv_o)    chk_ev(K_IINV, int'(ic_idx_o));
      if (done_o)      chk_ev(K_DONE, 0);
    end
  end

  // Cache responder: ack on the ack_lat-th write-back cycle,
  // remember probes so status can be returned the next cycle.
  always @(negedge sys_clk) begin
    if (dc_wb_req_o) begin
      wbcnt++;
      dc_wb_ack_i = (wbcnt >= ack_lat);
    end else begin
      wbcnt = 0;
      dc_wb_ack_i = spur_ack;
    end
    probed = dc_probe_o;
    pidx = int'(dc_idx_o);
  end

  always @(posedge sys_clk) begin
    #1;
    dc_valid_i = probed ? lv[pidx] : 1'b0;
    dc_dirty_i = probed ? ld[pidx] : 1'b0;
  end

  task automatic set_lines(input bit [DL-1:0] v,
                           input bit [DL-1:0] d);
    for (int i = 0; i < DL; i++) begin
      lv[i] = v[i];
      ld[i] = d[i];
    end
  endtask

  // Expected event stream for one sync with the current lines.
  task automatic expect_walk(input bit ic, input bit dc);
    for (int i = 0; i < DL; i++) begin
      sb.push_back(K_PROBE * 256 + i);
      if (lv[i] && ld[i]) begin
        for (int w = 0; w < ack_lat; w++)
          sb.push_back(K_WB * 256 + i);
      end
      if (lv[i] && dc) sb.push_back(K_DINV * 256 + i);
    end
    if (ic) begin
      for (int i = 0; i < IL; i++)
        sb.push_back(K_IINV * 256 + i);
    end
    sb.push_back(K_DONE * 256);
  endtask

  task automatic run_sync(input bit ic, input bit dc,
                          input int exp_stall, input string nm);
    int st;
    bit got;
    st = 0;
    got = 1'b0;
    expect_walk(ic, dc);
    @(negedge sys_clk);
    id_valid_i = 1'b1;
    sync_icache_i = ic;
    sync_dcache_i = dc;
    #1;
    for (int c = 0; c < 300; c++) begin
      if (done_o) begin
        got = 1'b1;
        break;
      end
      if (stall_o) st++;
      @(negedge sys_clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: done_o never seen", nm);
    end
    check({nm, "_stall_cycles"}, st, exp_stall);
    check({nm, "_stall_at_done"}, int'(stall_o), 0);
    check({nm, "_busy_at_done"}, int'(busy_o), 0);
    id_valid_i = 1'b0;
    sync_icache_i = 1'b0;
    sync_dcache_i = 1'b0;
    @(negedge sys_clk);
    #1;
    check({nm, "_queue_left"}, sb.size(), 0);
    sb.delete();
  endtask

  int outs;
  bit seen;

  initial begin
    set_lines(4'b0000, 4'b0000);
    #12;
    outs = int'({stall_o, busy_o, done_o, dc_idx_o, dc_probe_o,
                 dc_wb_req_o, dc_inv_o, ic_idx_o, ic_inv_o});
    check("reset_outputs", outs, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // T1: dcache sync, all lines invalid
    ack_lat = 1;
    run_sync(1'b0, 1'b1, 9, "t1");

    // T2: line 2 dirty, ack on third write-back cycle
    set_lines(4'b0100, 4'b0100);
    ack_lat = 3;
    run_sync(1'b0, 1'b1, 13, "t2");

    // T3: icache sync, line 1 dirty, immediate ack
    set_lines(4'b0010, 4'b0010);
    ack_lat = 1;
    run_sync(1'b1, 1'b0, 14, "t3");

    // T4: both syncs, all lines valid and clean
    set_lines(4'b1111, 4'b0000);
    run_sync(1'b1, 1'b1, 17, "t4");

    // T5: async reset during write-back of line 1
    mon_en = 1'b0;
    set_lines(4'b0010, 4'b0010);
    ack_lat = 1000;
    seen = 1'b0;
    @(negedge sys_clk);
    id_valid_i = 1'b1;
    sync_dcache_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge sys_clk);
      #1;
      if (dc_wb_req_o && dc_idx_o == 2'd1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_reached_wb_line1", int'(seen), 1);
    #1;
    rst_n = 1'b0;
    id_valid_i = 1'b0;
    sync_dcache_i = 1'b0;
    #1;
    outs = int'({stall_o, busy_o, done_o, dc_idx_o, dc_probe_o,
                 dc_wb_req_o, dc_inv_o, ic_idx_o, ic_inv_o});
    check("t5_outputs_in_reset", outs, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    sb.delete();
    set_lines(4'b0000, 4'b0000);
    ack_lat = 1;
    mon_en = 1'b1;
    run_sync(1'b0, 1'b1, 9, "t5_restart");

    // T6: sync without id_valid, spurious ack in IDLE
    @(negedge sys_clk);
    sync_dcache_i = 1'b1;
    spur_ack = 1'b1;
    #1;
    check("t6_stall_no_valid", int'(stall_o), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      #1;
    end
    check("t6_busy_no_valid", int'(busy_o), 0);
    check("t6_stall_later", int'(stall_o), 0);
    sync_dcache_i = 1'b0;
    spur_ack = 1'b0;
    run_sync(1'b0, 1'b1, 9, "t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
